// File: rtl/mem_lsu.sv
// mem_lsu: MEM-stage load/store unit for the RV64 pipeline.
// Turns ex_mem load/store requests into a valid/ready bus transaction
// (one outstanding, in-order responses), aligns byte lanes, sign/zero-extends
// loads, and raises misalignment, access-fault and timeout exceptions.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   ren_i/wen_i/funct3_i     memory op request, size and signedness
//   addr_i/wdata_i           byte address and right-aligned store data
//   rd_*_i/reg_wen_i         writeback fields passed through to mem_wb
//   inst_addr_i              pc of the instruction
//   bus_req_*                request channel (registered outputs)
//   bus_resp_*               response channel (always accepted)
//   wb_valid_o, rd_*_o       writeback pulse and fields to mem_wb
//   stall_o                  combinational hold request to ctrl
//   exc_*_o                  exception pulse, cause and faulting address
module mem_lsu #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned ADDR_W  = 64,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ren_i,
  input  logic                 wen_i,
  input  logic [2:0]           funct3_i,
  input  logic [ADDR_W-1:0]    addr_i,
  input  logic [XLEN-1:0]      wdata_i,
  input  logic [4:0]           rd_waddr_i,
  input  logic [XLEN-1:0]      rd_wdata_i,
  input  logic                 reg_wen_i,
  input  logic [ADDR_W-1:0]    inst_addr_i,
  output logic                 bus_req_valid_o,
  input  logic                 bus_req_ready_i,
  output logic                 bus_req_we_o,
  output logic [ADDR_W-1:0]    bus_req_addr_o,
  output logic [XLEN-1:0]      bus_req_wdata_o,
  output logic [XLEN/8-1:0]    bus_req_wstrb_o,
  input  logic                 bus_resp_valid_i,
  input  logic [XLEN-1:0]      bus_resp_rdata_i,
  input  logic                 bus_resp_err_i,
  output logic                 wb_valid_o,
  output logic [4:0]           rd_waddr_o,
  output logic [XLEN-1:0]      rd_wdata_o,
  output logic                 reg_wen_o,
  output logic [ADDR_W-1:0]    inst_addr_o,
  output logic                 stall_o,
  output logic                 exc_valid_o,
  output logic [3:0]           exc_cause_o,
  output logic [ADDR_W-1:0]    exc_tval_o
);

  localparam int unsigned STRB_W = XLEN / 8;
  localparam int unsigned OFF_W  = $clog2(STRB_W);
  localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                drop_q, drop_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  // Latched operation for the transaction in flight
  logic                op_we_q, op_we_d;
  logic [2:0]          op_f3_q, op_f3_d;
  logic [ADDR_W-1:0]   op_addr_q, op_addr_d;
  logic [4:0]          op_rd_q, op_rd_d;
  logic                op_rwen_q, op_rwen_d;
  logic [ADDR_W-1:0]   op_pc_q, op_pc_d;

  logic                bus_req_valid_q, bus_req_valid_d;
  logic                bus_req_we_q, bus_req_we_d;
  logic [ADDR_W-1:0]   bus_req_addr_q, bus_req_addr_d;
  logic [XLEN-1:0]     bus_req_wdata_q, bus_req_wdata_d;
  logic [STRB_W-1:0]   bus_req_wstrb_q, bus_req_wstrb_d;
  logic                wb_valid_q, wb_valid_d;
  logic [4:0]          rd_waddr_q, rd_waddr_d;
  logic [XLEN-1:0]     rd_wdata_q, rd_wdata_d;
  logic                reg_wen_q, reg_wen_d;
  logic [ADDR_W-1:0]   inst_addr_q, inst_addr_d;
  logic                exc_valid_q, exc_valid_d;
  logic [3:0]          exc_cause_q, exc_cause_d;
  logic [ADDR_W-1:0]   exc_tval_q, exc_tval_d;

  logic                stall_c;
  logic                misalign_c;
  logic [STRB_W-1:0]   strb_mask_c;
  logic [XLEN-1:0]     rsh_c;
  logic [XLEN-1:0]     load_data_c;
  logic                resp_ok_c;

  // Natural-alignment check and byte-lane mask for the requested size
  always_comb begin
    misalign_c  = 1'b0;
    strb_mask_c = '0;
    case (funct3_i[1:0])
      2'd0: begin misalign_c = 1'b0;           strb_mask_c = STRB_W'(1);   end
      2'd1: begin misalign_c = addr_i[0];      strb_mask_c = STRB_W'(3);   end
      2'd2: begin misalign_c = |addr_i[1:0];   strb_mask_c = STRB_W'(15);  end
      default: begin misalign_c = |addr_i[2:0]; strb_mask_c = STRB_W'(255); end
    endcase
  end

  // Right-align the addressed lanes of the response, then extend
  always_comb begin
    rsh_c = bus_resp_rdata_i >> {op_addr_q[OFF_W-1:0], 3'b000};
    case (op_f3_q)
      3'b000:  load_data_c = XLEN'($signed(rsh_c[7:0]));
      3'b001:  load_data_c = XLEN'($signed(rsh_c[15:0]));
      3'b010:  load_data_c = XLEN'($signed(rsh_c[31:0]));
      3'b100:  load_data_c = XLEN'(rsh_c[7:0]);
      3'b101:  load_data_c = XLEN'(rsh_c[15:0]);
      3'b110:  load_data_c = XLEN'(rsh_c[31:0]);
      default: load_data_c = rsh_c;
    endcase
  end

  // A response is ours only if no timed-out response is still owed
  assign resp_ok_c = bus_resp_valid_i & ~drop_q;

  // Next-state and registered-output logic
  always_comb begin
    state_d         = state_q;
    drop_d          = drop_q;
    cnt_d           = cnt_q;
    op_we_d         = op_we_q;
    op_f3_d         = op_f3_q;
    op_addr_d       = op_addr_q;
    op_rd_d         = op_rd_q;
    op_rwen_d       = op_rwen_q;
    op_pc_d         = op_pc_q;
    bus_req_valid_d = bus_req_valid_q;
    bus_req_we_d    = bus_req_we_q;
    bus_req_addr_d  = bus_req_addr_q;
    bus_req_wdata_d = bus_req_wdata_q;
    bus_req_wstrb_d = bus_req_wstrb_q;
    wb_valid_d      = 1'b0;
    rd_waddr_d      = rd_waddr_q;
    rd_wdata_d      = rd_wdata_q;
    reg_wen_d       = 1'b0;
    inst_addr_d     = inst_addr_q;
    exc_valid_d     = 1'b0;
    exc_cause_d     = exc_cause_q;
    exc_tval_d      = exc_tval_q;
    stall_c         = 1'b0;

    // The stale response owed after a timeout is swallowed in any state
    if (bus_resp_valid_i && drop_q) drop_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!(ren_i || wen_i)) begin
          wb_valid_d  = 1'b1;
          rd_waddr_d  = rd_waddr_i;
          rd_wdata_d  = rd_wdata_i;
          reg_wen_d   = reg_wen_i;
          inst_addr_d = inst_addr_i;
        end else if (misalign_c) begin
          exc_valid_d = 1'b1;
          exc_cause_d = wen_i ? 4'd6 : 4'd4;
          exc_tval_d  = addr_i;
          rd_waddr_d  = rd_waddr_i;
          inst_addr_d = inst_addr_i;
        end else begin
          state_d         = S_REQ;
          stall_c         = 1'b1;
          op_we_d         = wen_i;
          op_f3_d         = funct3_i;
          op_addr_d       = addr_i;
          op_rd_d         = rd_waddr_i;
          op_rwen_d       = reg_wen_i;
          op_pc_d         = inst_addr_i;
          bus_req_valid_d = 1'b1;
          bus_req_we_d    = wen_i;
          bus_req_addr_d  = {addr_i[ADDR_W-1:OFF_W], OFF_W'(0)};
          bus_req_wdata_d = wen_i ? (wdata_i << {addr_i[OFF_W-1:0], 3'b000}) : '0;
          bus_req_wstrb_d = wen_i ? (strb_mask_c << addr_i[OFF_W-1:0]) : '0;
        end
      end
      S_REQ: begin
        stall_c = 1'b1;
        if (bus_req_ready_i) begin
          bus_req_valid_d = 1'b0;
          state_d         = S_WAIT;
          cnt_d           = '0;
        end
      end
      S_WAIT: begin
        stall_c = 1'b1;
        if (resp_ok_c) begin
          stall_c     = 1'b0;
          state_d     = S_IDLE;
          rd_waddr_d  = op_rd_q;
          inst_addr_d = op_pc_q;
          if (bus_resp_err_i) begin
            exc_valid_d = 1'b1;
            exc_cause_d = op_we_q ? 4'd7 : 4'd5;
            exc_tval_d  = op_addr_q;
          end else begin
            wb_valid_d = 1'b1;
            rd_wdata_d = op_we_q ? '0 : load_data_c;
            reg_wen_d  = op_rwen_q & ~op_we_q;
          end
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT))) begin
          // Give up; the response still owed by the agent must be discarded
          stall_c     = 1'b0;
          state_d     = S_IDLE;
          drop_d      = 1'b1;
          exc_valid_d = 1'b1;
          exc_cause_d = op_we_q ? 4'd7 : 4'd5;
          exc_tval_d  = op_addr_q;
          rd_waddr_d  = op_rd_q;
          inst_addr_d = op_pc_q;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= S_IDLE;
      drop_q          <= 1'b0;
      cnt_q           <= '0;
      op_we_q         <= 1'b0;
      op_f3_q         <= '0;
      op_addr_q       <= '0;
      op_rd_q         <= '0;
      op_rwen_q       <= 1'b0;
      op_pc_q         <= '0;
      bus_req_valid_q <= 1'b0;
      bus_req_we_q    <= 1'b0;
      bus_req_addr_q  <= '0;
      bus_req_wdata_q <= '0;
      bus_req_wstrb_q <= '0;
      wb_valid_q      <= 1'b0;
      rd_waddr_q      <= '0;
      rd_wdata_q      <= '0;
      reg_wen_q       <= 1'b0;
      inst_addr_q     <= '0;
      exc_valid_q     <= 1'b0;
      exc_cause_q     <= '0;
      exc_tval_q      <= '0;
    end else begin
      state_q         <= state_d;
      drop_q          <= drop_d;
      cnt_q           <= cnt_d;
      op_we_q         <= op_we_d;
      op_f3_q         <= op_f3_d;
      op_addr_q       <= op_addr_d;
      op_rd_q         <= op_rd_d;
      op_rwen_q       <= op_rwen_d;
      op_pc_q         <= op_pc_d;
      bus_req_valid_q <= bus_req_valid_d;
      bus_req_we_q    <= bus_req_we_d;
      bus_req_addr_q  <= bus_req_addr_d;
      bus_req_wdata_q <= bus_req_wdata_d;
      bus_req_wstrb_q <= bus_req_wstrb_d;
      wb_valid_q      <= wb_valid_d;
      rd_waddr_q      <= rd_waddr_d;
      rd_wdata_q      <= rd_wdata_d;
      reg_wen_q       <= reg_wen_d;
      inst_addr_q     <= inst_addr_d;
      exc_valid_q     <= exc_valid_d;
      exc_cause_q     <= exc_cause_d;
      exc_tval_q      <= exc_tval_d;
    end
  end

  assign bus_req_valid_o = bus_req_valid_q;
  assign bus_req_we_o    = bus_req_we_q;
  assign bus_req_addr_o  = bus_req_addr_q;
  assign bus_req_wdata_o = bus_req_wdata_q;
  assign bus_req_wstrb_o = bus_req_wstrb_q;
  assign wb_valid_o      = wb_valid_q;
  assign rd_waddr_o      = rd_waddr_q;
  assign rd_wdata_o      = rd_wdata_q;
  assign reg_wen_o       = reg_wen_q;
  assign inst_addr_o     = inst_addr_q;
  assign exc_valid_o     = exc_valid_q;
  assign exc_cause_o     = exc_cause_q;
  assign exc_tval_o      = exc_tval_q;
  // Held low during reset so ctrl sees every output at 0
  assign stall_o         = stall_c & rst;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed bench for mem_lsu with an expected-result queue.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ren_i, wen_i;
  logic [2:0]  funct3_i;
  logic [63:0] addr_i, wdata_i, rd_wdata_i, inst_addr_i;
  logic [4:0]  rd_waddr_i;
  logic        reg_wen_i;
  logic        bus_req_valid_o, bus_req_ready_i, bus_req_we_o;
  logic [63:0] bus_req_addr_o, bus_req_wdata_o;
  logic [7:0]  bus_req_wstrb_o;
  logic        bus_resp_valid_i, bus_resp_err_i;
  logic [63:0] bus_resp_rdata_i;
  logic        wb_valid_o, reg_wen_o, stall_o, exc_valid_o;
  logic [4:0]  rd_waddr_o;
  logic [63:0] rd_wdata_o, inst_addr_o, exc_tval_o;
  logic [3:0]  exc_cause_o;

  mem_lsu #(.XLEN(64), .ADDR_W(64), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ren_i(ren_i), .wen_i(wen_i), .funct3_i(funct3_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .rd_waddr_i(rd_waddr_i), .rd_wdata_i(rd_wdata_i),
    .reg_wen_i(reg_wen_i), .inst_addr_i(inst_addr_i),
    .bus_req_valid_o(bus_req_valid_o), .bus_req_ready_i(bus_req_ready_i),
    .bus_req_we_o(bus_req_we_o), .bus_req_addr_o(bus_req_addr_o),
    .bus_req_wdata_o(bus_req_wdata_o), .bus_req_wstrb_o(bus_req_wstrb_o),
    .bus_resp_valid_i(bus_resp_valid_i), .bus_resp_rdata_i(bus_resp_rdata_i),
    .bus_resp_err_i(bus_resp_err_i),
    .wb_valid_o(wb_valid_o), .rd_waddr_o(rd_waddr_o), .rd_wdata_o(rd_wdata_o),
    .reg_wen_o(reg_wen_o), .inst_addr_o(inst_addr_o), .stall_o(stall_o),
    .exc_valid_o(exc_valid_o), .exc_cause_o(exc_cause_o), .exc_tval_o(exc_tval_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        exc;
    logic [3:0]  cause;
    logic [63:0] val;    // load/ALU data, or tval for exceptions
    logic [4:0]  rd;
    logic        rwen;
    logic [63:0] pc;
    logic        chk_data;
  } exp_t;

  exp_t sb[$];
  int   nchk  = 0;
  int   npass = 0;
  int   nfail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Bubble inputs: pc 0 marks filler writebacks the monitor ignores
  task automatic idle_in();
    ren_i = 0; wen_i = 0; funct3_i = 0; addr_i = 0; wdata_i = 0;
    rd_waddr_i = 0; rd_wdata_i = 0; reg_wen_i = 0; inst_addr_i = 0;
  endtask

  // Scoreboard consumer: every real writeback or exception pops one entry
  exp_t m;
  always @(negedge clk) begin
    if (rst) begin
      chk("wb_exc_exclusive", 64'(wb_valid_o & exc_valid_o), 64'd0);
      if (exc_valid_o || (wb_valid_o && inst_addr_o != 64'd0)) begin
        if (sb.size() == 0) begin
          chk("unexpected_output", 64'(sb.size()), 64'd1);
        end else begin
          m = sb.pop_front();
          chk("out_is_exc", 64'(exc_valid_o), 64'(m.exc));
          if (m.exc) begin
            chk("exc_cause", 64'(exc_cause_o), 64'(m.cause));
            chk("exc_tval", exc_tval_o, m.val);
            chk("exc_reg_wen", 64'(reg_wen_o), 64'd0);
          end else begin
            if (m.chk_data) chk("wb_data", rd_wdata_o, m.val);
            chk("wb_rd", 64'(rd_waddr_o), 64'(m.rd));
            chk("wb_reg_wen", 64'(reg_wen_o), 64'(m.rwen));
            chk("wb_pc", inst_addr_o, m.pc);
          end
        end
      end
    end
  end

  task automatic alu(input logic [63:0] pc, input logic [4:0] rd,
                     input logic [63:0] val, input logic rwen);
    exp_t e;
    idle_in();
    inst_addr_i = pc; rd_waddr_i = rd; rd_wdata_i = val; reg_wen_i = rwen;
    e = '{exc: 1'b0, cause: 4'd0, val: val, rd: rd, rwen: rwen, pc: pc, chk_data: 1'b1};
    sb.push_back(e);
    @(negedge clk);
    chk("alu_stall", 64'(stall_o), 64'd0);
    cyc();
    idle_in();
    @(negedge clk);
    chk("alu_latency", 64'(wb_valid_o), 64'd1);
    cyc();
  endtask

  task automatic misal(input string tag, input logic we, input logic [2:0] f3,
                       input logic [63:0] addr, input logic [63:0] pc);
    exp_t e;
    idle_in();
    ren_i = !we; wen_i = we; funct3_i = f3; addr_i = addr; inst_addr_i = pc;
    rd_waddr_i = 5'd3; reg_wen_i = 1'b1;
    e = '{exc: 1'b1, cause: (we ? 4'd6 : 4'd4), val: addr, rd: 5'd3, rwen: 1'b0,
          pc: pc, chk_data: 1'b0};
    sb.push_back(e);
    @(negedge clk);
    chk({tag, "_stall"}, 64'(stall_o), 64'd0);
    chk({tag, "_no_req0"}, 64'(bus_req_valid_o), 64'd0);
    cyc();
    idle_in();
    @(negedge clk);
    chk({tag, "_exc_latency"}, 64'(exc_valid_o), 64'd1);
    chk({tag, "_no_req1"}, 64'(bus_req_valid_o), 64'd0);
    cyc();
    @(negedge clk);
    chk({tag, "_no_req2"}, 64'(bus_req_valid_o), 64'd0);
    cyc();
  endtask

  task automatic do_mem(input string tag, input logic we, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wdata,
                        input logic [63:0] pc, input int ready_lag, input int resp_lag,
                        input logic stale, input logic [63:0] rdata, input logic err,
                        input logic [63:0] exp_baddr, input logic [7:0] exp_strb,
                        input logic [63:0] exp_bwdata, input logic [63:0] exp_data);
    exp_t e;
    idle_in();
    ren_i = !we; wen_i = we; funct3_i = f3; addr_i = addr; wdata_i = wdata;
    inst_addr_i = pc; rd_waddr_i = 5'd7; reg_wen_i = 1'b1; rd_wdata_i = 64'h5555;
    @(negedge clk);
    chk({tag, "_stall_idle"}, 64'(stall_o), 64'd1);
    chk({tag, "_valid_idle"}, 64'(bus_req_valid_o), 64'd0);
    cyc();
    // Request must stay stable until accepted
    for (int i = 0; i <= ready_lag; i++) begin
      @(negedge clk);
      chk({tag, "_req_valid"}, 64'(bus_req_valid_o), 64'd1);
      chk({tag, "_req_addr"}, bus_req_addr_o, exp_baddr);
      chk({tag, "_req_we"}, 64'(bus_req_we_o), 64'(we));
      chk({tag, "_req_stall"}, 64'(stall_o), 64'd1);
      if (we) begin
        chk({tag, "_req_wstrb"}, 64'(bus_req_wstrb_o), 64'(exp_strb));
        chk({tag, "_req_wdata"}, bus_req_wdata_o, exp_bwdata);
      end
      bus_req_ready_i = (i == ready_lag);
      cyc();
    end
    bus_req_ready_i = 1'b0;
    if (stale) begin
      bus_resp_valid_i = 1'b1;
      bus_resp_rdata_i = 64'hDEAD_BEEF_DEAD_BEEF;
      @(negedge clk);
      chk({tag, "_stall_on_dropped"}, 64'(stall_o), 64'd1);
      cyc();
      bus_resp_valid_i = 1'b0;
    end
    repeat (resp_lag) begin
      @(negedge clk);
      chk({tag, "_wait_stall"}, 64'(stall_o), 64'd1);
      chk({tag, "_wait_novalid"}, 64'(bus_req_valid_o), 64'd0);
      cyc();
    end
    if (err)
      e = '{exc: 1'b1, cause: (we ? 4'd7 : 4'd5), val: addr, rd: 5'd7, rwen: 1'b0,
            pc: pc, chk_data: 1'b0};
    else
      e = '{exc: 1'b0, cause: 4'd0, val: exp_data, rd: 5'd7, rwen: !we, pc: pc,
            chk_data: !we};
    sb.push_back(e);
    bus_resp_valid_i = 1'b1;
    bus_resp_rdata_i = rdata;
    bus_resp_err_i   = err;
    @(negedge clk);
    chk({tag, "_stall_resp"}, 64'(stall_o), 64'd0);
    cyc();
    bus_resp_valid_i = 1'b0;
    bus_resp_err_i   = 1'b0;
    idle_in();
    @(negedge clk);
    chk({tag, "_result_latency"}, 64'(err ? exc_valid_o : wb_valid_o), 64'd1);
    cyc();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  int   n;
  logic done, st;
  exp_t e0;

  initial begin
    rst = 1'b0;
    idle_in();
    bus_req_ready_i = 0; bus_resp_valid_i = 0; bus_resp_err_i = 0; bus_resp_rdata_i = 0;
    ren_i = 1'b1;  // stall must still read 0 while in reset
    @(negedge clk);
    chk("rst_wb_valid", 64'(wb_valid_o), 64'd0);
    chk("rst_exc_valid", 64'(exc_valid_o), 64'd0);
    chk("rst_req_valid", 64'(bus_req_valid_o), 64'd0);
    chk("rst_stall", 64'(stall_o), 64'd0);
    chk("rst_rd_wdata", rd_wdata_o, 64'd0);
    cyc();
    idle_in();
    rst = 1'b1;
    cyc();

    alu(64'h100, 5'd5, 64'h1234_5678_9ABC_DEF0, 1'b1);
    alu(64'h104, 5'd6, 64'h0BAD_F00D, 1'b0);

    // LB at byte 3 holding 0x80 -> sign extended
    do_mem("lb", 0, 3'b000, 64'h8000_0003, 0, 64'h108, 0, 0, 0,
           64'h0123_4567_8022_3344, 0, 64'h8000_0000, 8'h00, 0, 64'hFFFF_FFFF_FFFF_FF80);
    do_mem("lbu", 0, 3'b100, 64'h8000_0003, 0, 64'h10C, 0, 1, 0,
           64'h0123_4567_8022_3344, 0, 64'h8000_0000, 8'h00, 0, 64'h80);
    // SH in the top lanes with ready held low three cycles
    do_mem("sh", 1, 3'b001, 64'h8000_0006, 64'hBEEF, 64'h110, 3, 1, 0,
           0, 0, 64'h8000_0000, 8'hC0, 64'hBEEF_0000_0000_0000, 0);
    do_mem("lh", 0, 3'b001, 64'h8000_0004, 0, 64'h114, 0, 0, 0,
           64'h1234_8001_5555_6666, 0, 64'h8000_0000, 8'h00, 0, 64'hFFFF_FFFF_FFFF_8001);
    do_mem("lwu", 0, 3'b110, 64'h8000_0004, 0, 64'h118, 1, 2, 0,
           64'h8765_4321_0000_0000, 0, 64'h8000_0000, 8'h00, 0, 64'h8765_4321);
    do_mem("lw", 0, 3'b010, 64'h8000_0000, 0, 64'h11C, 0, 0, 0,
           64'hFFFF_FFFF_7FFF_FFFF, 0, 64'h8000_0000, 8'h00, 0, 64'h7FFF_FFFF);
    do_mem("lhu", 0, 3'b101, 64'h8000_0002, 0, 64'h120, 0, 0, 0,
           64'h0000_0000_F00D_0000, 0, 64'h8000_0000, 8'h00, 0, 64'hF00D);
    do_mem("ld", 0, 3'b011, 64'h8000_0008, 0, 64'h124, 0, 0, 0,
           64'hFEDC_BA98_7654_3210, 0, 64'h8000_0008, 8'h00, 0, 64'hFEDC_BA98_7654_3210);
    // Store data is shifted whole; strobes select the valid lanes
    do_mem("sb", 1, 3'b000, 64'h8000_0001, 64'hFFFF_FFFF_FFFF_FF5A, 64'h128, 0, 0, 0,
           0, 0, 64'h8000_0000, 8'h02, 64'hFFFF_FFFF_FFFF_5A00, 0);
    do_mem("sw", 1, 3'b010, 64'h8000_0004, 64'h1122_3344, 64'h12C, 1, 0, 0,
           0, 0, 64'h8000_0000, 8'hF0, 64'h1122_3344_0000_0000, 0);
    do_mem("sd", 1, 3'b011, 64'h8000_0018, 64'hA5A5_0000_FFFF_1234, 64'h130, 0, 0, 0,
           0, 0, 64'h8000_0018, 8'hFF, 64'hA5A5_0000_FFFF_1234, 0);

    misal("lw_misal", 0, 3'b010, 64'h8000_0002, 64'h134);
    misal("sh_misal", 1, 3'b001, 64'h8000_0001, 64'h138);
    misal("ld_misal", 0, 3'b011, 64'h8000_0004, 64'h13C);

    do_mem("lw_err", 0, 3'b010, 64'h8000_0040, 0, 64'h140, 0, 1, 0,
           64'h1, 1, 64'h8000_0040, 8'h00, 0, 0);
    do_mem("sd_err", 1, 3'b011, 64'h8000_0048, 64'h77, 64'h144, 0, 0, 0,
           0, 1, 64'h8000_0048, 8'hFF, 64'h77, 0);

    // Timeout: no response. Eight full WAIT cycles (counter 0..7), the fault is
    // raised in the ninth (counter == 8) and the exception shows the cycle after.
    idle_in();
    ren_i = 1; funct3_i = 3'b011; addr_i = 64'h8000_0010; inst_addr_i = 64'h148;
    rd_waddr_i = 5'd9; reg_wen_i = 1;
    @(negedge clk);
    cyc();
    bus_req_ready_i = 1'b1;
    @(negedge clk);
    cyc();
    bus_req_ready_i = 1'b0;
    e0 = '{exc: 1'b1, cause: 4'd5, val: 64'h8000_0010, rd: 5'd9, rwen: 1'b0,
           pc: 64'h148, chk_data: 1'b0};
    sb.push_back(e0);
    n = 0;
    done = 1'b0;
    while (!done && n < 20) begin
      @(negedge clk);
      if (exc_valid_o) done = 1'b1;
      else begin
        st = stall_o;
        n++;
        cyc();
        if (!st) idle_in();
      end
    end
    chk("timeout_latency", 64'(n), 64'd9);
    cyc();
    // New LD while the timed-out response is still owed: first response dropped
    do_mem("ld_after_to", 0, 3'b011, 64'h8000_0020, 0, 64'h14C, 0, 1, 1,
           64'h0123_4567_89AB_CDEF, 0, 64'h8000_0020, 8'h00, 0, 64'h0123_4567_89AB_CDEF);
    do_mem("ld_after_drop", 0, 3'b010, 64'h8000_0024, 0, 64'h150, 0, 0, 0,
           64'h0000_0042_0000_0000, 0, 64'h8000_0020, 8'h00, 0, 64'h42);

    // Reset while waiting for a response
    idle_in();
    ren_i = 1; funct3_i = 3'b011; addr_i = 64'h8000_0030; inst_addr_i = 64'h154;
    rd_waddr_i = 5'd4; reg_wen_i = 1;
    @(negedge clk);
    cyc();
    bus_req_ready_i = 1'b1;
    @(negedge clk);
    cyc();
    bus_req_ready_i = 1'b0;
    cyc();
    rst = 1'b0;
    #1;
    chk("midrst_stall", 64'(stall_o), 64'd0);
    chk("midrst_req_valid", 64'(bus_req_valid_o), 64'd0);
    chk("midrst_req_addr", bus_req_addr_o, 64'd0);
    chk("midrst_exc_tval", exc_tval_o, 64'd0);
    chk("midrst_exc_cause", 64'(exc_cause_o), 64'd0);
    chk("midrst_wb_valid", 64'(wb_valid_o), 64'd0);
    idle_in();
    cyc();
    rst = 1'b1;
    cyc();
    do_mem("ld_post_rst", 0, 3'b011, 64'h8000_0038, 0, 64'h158, 0, 1, 0,
           64'h1111_2222_3333_4444, 0, 64'h8000_0038, 8'h00, 0, 64'h1111_2222_3333_4444);

    repeat (3) cyc();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
